// File: rtl/if_id_stage.sv
// if_id_stage: RV32I front end. Owns the fetch PC and the IF/ID pipeline
// register, detects load-use hazards against the instruction in EX, and
// applies EX-stage redirects by loading the target and squashing IF/ID.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrIn,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic [4:0]  exRd,
  input  logic        exLw,
  input  logic        extStall,
  output logic [31:0] pcFetch,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic [31:0] pcAdd4Out,
  output logic        validOut,
  output logic        bubbleEx,
  output logic        hazardStall
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  // Fetch-side PC and IF/ID register contents
  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pcadd4_p1;
  logic        vld_p1;

  logic [6:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        haz;
  logic [31:0] pc_next_seq;

  assign op  = instr_p1[6:0];
  assign rs1 = instr_p1[19:15];
  assign rs2 = instr_p1[24:20];

  // PC increment wraps modulo 2^32 with no overflow flag
  assign pc_next_seq = pc_p0 + 32'd4;

  // Load-use detection: compare the sources read by the IF/ID instruction
  // against the destination of a load sitting in EX (x0 never conflicts)
  always_comb begin
    uses_rs1 = vld_p1 && (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    uses_rs2 = vld_p1 && ((op == OP_R) || (op == OP_S) || (op == OP_B));
    haz      = exLw && (exRd != 5'd0) &&
               ((uses_rs1 && (rs1 == exRd)) || (uses_rs2 && (rs2 == exRd)));
  end

  assign hazardStall = haz;
  assign bubbleEx    = haz || redirect;

  // Front-end state update: reset, then redirect > extStall > hazard > advance
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0     <= RESET_PC;
      instr_p1  <= NOP_INSTR;
      pc_p1     <= 32'd0;
      pcadd4_p1 <= 32'd0;
      vld_p1    <= 1'b0;
    end else if (redirect) begin
      pc_p0     <= redirectPc;
      instr_p1  <= NOP_INSTR;
      pc_p1     <= 32'd0;
      pcadd4_p1 <= 32'd0;
      vld_p1    <= 1'b0;
    end else if (extStall || haz) begin
      pc_p0     <= pc_p0;
      instr_p1  <= instr_p1;
      pc_p1     <= pc_p1;
      pcadd4_p1 <= pcadd4_p1;
      vld_p1    <= vld_p1;
    end else begin
      pc_p0     <= pc_next_seq;
      instr_p1  <= instrIn;
      pc_p1     <= pc_p0;
      pcadd4_p1 <= pc_next_seq;
      vld_p1    <= 1'b1;
    end
  end

  assign pcFetch   = pc_p0;
  assign instrOut  = instr_p1;
  assign pcOut     = pc_p1;
  assign pcAdd4Out = pcadd4_p1;
  assign validOut  = vld_p1;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instrIn;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [4:0]  exRd;
  logic        exLw;
  logic        extStall;
  logic [31:0] pcFetch;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic [31:0] pcAdd4Out;
  logic        validOut;
  logic        bubbleEx;
  logic        hazardStall;

  int checks;
  int failures;

  if_id_stage #(
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instrIn    (instrIn),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .exRd       (exRd),
    .exLw       (exLw),
    .extStall   (extStall),
    .pcFetch    (pcFetch),
    .instrOut   (instrOut),
    .pcOut      (pcOut),
    .pcAdd4Out  (pcAdd4Out),
    .validOut   (validOut),
    .bubbleEx   (bubbleEx),
    .hazardStall(hazardStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] instr;
    logic        redir;
    logic [31:0] rpc;
    logic [4:0]  rd;
    logic        lw;
    logic        stall;
    logic        e_haz;
    logic        e_bub;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pcout;
    logic [31:0] e_add4;
    logic        e_vld;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic [31:0] instr, logic redir,
                              logic [31:0] rpc, logic [4:0] rd, logic lw,
                              logic stall, logic e_haz, logic e_bub,
                              logic [31:0] e_pc, logic [31:0] e_instr,
                              logic [31:0] e_pcout, logic [31:0] e_add4,
                              logic e_vld);
    vec_t v;
    v.rst_n = rst_n; v.instr = instr; v.redir = redir; v.rpc = rpc;
    v.rd = rd; v.lw = lw; v.stall = stall; v.e_haz = e_haz; v.e_bub = e_bub;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcout = e_pcout;
    v.e_add4 = e_add4; v.e_vld = e_vld;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s actual=%h required=%h", idx, name, act, exp);
    end
  endtask

  // Drive one vector away from the edge, check the combinational outputs,
  // clock it in, then check the registered outputs.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    reset      = v.rst_n;
    instrIn    = v.instr;
    redirect   = v.redir;
    redirectPc = v.rpc;
    exRd       = v.rd;
    exLw       = v.lw;
    extStall   = v.stall;
    #1;
    chk("hazardStall", idx, {31'd0, hazardStall}, {31'd0, v.e_haz});
    chk("bubbleEx",    idx, {31'd0, bubbleEx},    {31'd0, v.e_bub});
    @(posedge clk);
    #1;
    chk("pcFetch",   idx, pcFetch,   v.e_pc);
    chk("instrOut",  idx, instrOut,  v.e_instr);
    chk("pcOut",     idx, pcOut,     v.e_pcout);
    chk("pcAdd4Out", idx, pcAdd4Out, v.e_add4);
    chk("validOut",  idx, {31'd0, validOut}, {31'd0, v.e_vld});
  endtask

  localparam logic [31:0] ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] LUI   = 32'h000122B7; // lui  x5,0x12 (rs1 field = 2)
  localparam logic [31:0] ADDI2 = 32'h00108113; // addi x2,x1,1
  localparam logic [31:0] SW    = 32'h0050A023; // sw   x5,0(x1)
  localparam logic [31:0] NOP   = 32'h00000013;

  vec_t vt[25];

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0; instrIn = '0; redirect = 1'b0; redirectPc = '0;
    exRd = '0; exLw = 1'b0; extStall = 1'b0;

    //          rst instr  rdr rpc           rd lw st  haz bub  pc            instr  pcOut         add4          vld
    vt[0]  = mk(0, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        NOP,   32'h0,        32'h0,        0);
    vt[1]  = mk(0, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        NOP,   32'h0,        32'h0,        0);
    vt[2]  = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h4,        ADDI,  32'h0,        32'h4,        1);
    vt[3]  = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h8,        ADDI,  32'h4,        32'h8,        1);
    vt[4]  = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'hC,        ADDI,  32'h8,        32'hC,        1);
    vt[5]  = mk(1, ADD,   0, 32'h0,        0, 0, 0,  0, 0, 32'h10,       ADD,   32'hC,        32'h10,       1);
    // load-use on rs2 of add: hold one cycle, then resume
    vt[6]  = mk(1, ADDI,  0, 32'h0,        2, 1, 0,  1, 1, 32'h10,       ADD,   32'hC,        32'h10,       1);
    vt[7]  = mk(1, LUI,   0, 32'h0,        2, 0, 0,  0, 0, 32'h14,       LUI,   32'h10,       32'h14,       1);
    // lui reads no registers: no hazard for rd=0, rd=5, or its rs1 field
    vt[8]  = mk(1, ADDI,  0, 32'h0,        0, 1, 1,  0, 0, 32'h14,       LUI,   32'h10,       32'h14,       1);
    vt[9]  = mk(1, ADDI,  0, 32'h0,        5, 1, 1,  0, 0, 32'h14,       LUI,   32'h10,       32'h14,       1);
    vt[10] = mk(1, ADDI,  0, 32'h0,        2, 1, 1,  0, 0, 32'h14,       LUI,   32'h10,       32'h14,       1);
    vt[11] = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h18,       ADDI,  32'h14,       32'h18,       1);
    // addi with rs1=x0 against a load of x0: no hazard
    vt[12] = mk(1, ADDI2, 0, 32'h0,        0, 1, 0,  0, 0, 32'h1C,       ADDI2, 32'h18,       32'h1C,       1);
    vt[13] = mk(1, ADDI2, 0, 32'h0,        0, 0, 0,  0, 0, 32'h20,       ADDI2, 32'h1C,       32'h20,       1);
    // redirect beats hazard and extStall together
    vt[14] = mk(1, ADDI,  1, 32'h100,      1, 1, 1,  1, 1, 32'h100,      NOP,   32'h0,        32'h0,        0);
    vt[15] = mk(1, ADDI,  0, 32'h0,        1, 1, 0,  0, 0, 32'h104,      ADDI,  32'h100,      32'h104,      1);
    vt[16] = mk(1, ADDI,  1, 32'h40,       0, 0, 0,  0, 1, 32'h40,       NOP,   32'h0,        32'h0,        0);
    // extStall for three cycles at 0x40
    vt[17] = mk(1, ADDI,  0, 32'h0,        0, 0, 1,  0, 0, 32'h40,       NOP,   32'h0,        32'h0,        0);
    vt[18] = mk(1, ADDI,  0, 32'h0,        0, 0, 1,  0, 0, 32'h40,       NOP,   32'h0,        32'h0,        0);
    vt[19] = mk(1, ADDI,  0, 32'h0,        0, 0, 1,  0, 0, 32'h40,       NOP,   32'h0,        32'h0,        0);
    vt[20] = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h44,       ADDI,  32'h40,       32'h44,       1);
    // wrap at the top of the address space
    vt[21] = mk(1, ADDI,  1, 32'hFFFFFFFC, 0, 0, 0,  0, 1, 32'hFFFFFFFC, NOP,   32'h0,        32'h0,        0);
    vt[22] = mk(1, ADDI,  0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        ADDI,  32'hFFFFFFFC, 32'h0,        1);
    // unaligned target taken verbatim, then reset wins over redirect
    vt[23] = mk(1, ADDI,  1, 32'h102,      0, 0, 0,  0, 1, 32'h102,      NOP,   32'h0,        32'h0,        0);
    vt[24] = mk(0, ADDI,  1, 32'h200,      0, 0, 0,  0, 1, 32'h0,        NOP,   32'h0,        32'h0,        0);

    for (int i = 0; i < 25; i++) step(vt[i], i);

    // Hand sequence: store reads rs2; hazard holds, non-matching rd frees it
    step(mk(1, SW,   0, 32'h0, 0, 0, 0, 0, 0, 32'h4, SW, 32'h0, 32'h4, 1), 100);
    step(mk(1, ADDI, 0, 32'h0, 5, 1, 0, 1, 1, 32'h4, SW, 32'h0, 32'h4, 1), 101);
    step(mk(1, ADDI, 0, 32'h0, 3, 1, 0, 0, 0, 32'h8, ADDI, 32'h4, 32'h8, 1), 102);

    // Hand sequence: load-use on rs1 of addi, self-clearing after one cycle
    step(mk(1, ADDI, 0, 32'h0, 1, 1, 0, 0, 0, 32'hC, ADDI, 32'h8, 32'hC, 1), 103);
    step(mk(1, ADDI2,0, 32'h0, 0, 0, 0, 0, 0, 32'h10, ADDI2, 32'hC, 32'h10, 1), 104);
    step(mk(1, ADDI, 0, 32'h0, 1, 1, 0, 1, 1, 32'h10, ADDI2, 32'hC, 32'h10, 1), 105);
    step(mk(1, ADDI, 0, 32'h0, 1, 0, 0, 0, 0, 32'h14, ADDI, 32'h10, 32'h14, 1), 106);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Front end of the 5-stage RV32I pipeline: owns the program counter, drives instruction-memory fetch address, and holds the IF/ID pipeline register that feeds the decoder and ID/EX register.
- Contains the load-use hazard detector: freezes PC and IF/ID and requests a bubble into ID/EX.
- Applies branch/jump redirects from EX by loading the target PC and squashing the wrong-path fetch.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous active-low reset; sampled on rising clk edge only.
- instrIn  in  32  instruction word from instruction memory for address pcFetch; combinational, same cycle.
- redirect  in  1  EX-stage taken branch/jump/jalr.
- redirectPc  in  32  target PC, valid when redirect=1.
- exRd  in  5  destination register of instruction currently in EX (ID/EX rdOut).
- exLw  in  1  instruction in EX is a load (ID/EX lwOut).
- extStall  in  1  external freeze (e.g. memory not ready); holds front end, no bubble.
- pcFetch  out  32  current PC, instruction-memory address.
- instrOut  out  32  IF/ID instruction.
- pcOut  out  32  IF/ID PC of instrOut.
- pcAdd4Out  out  32  IF/ID pcOut+4.
- validOut  out  1  IF/ID holds a real (non-squashed) instruction.
- bubbleEx  out  1  combinational; ID/EX must load a bubble this cycle.
- hazardStall  out  1  combinational; load-use stall active this cycle.

Behaviour:
- Reset (reset=0 at edge): pcFetch=RESET_PC, instrOut=NOP_INSTR, pcOut=0, pcAdd4Out=0, validOut=0. bubbleEx/hazardStall evaluate from reset-state registers (0 with NOP). Reset mid-operation discards everything, including a pending redirect.
- Decode of instrOut for hazard: op=[6:0], rs1=[19:15], rs2=[24:20].
- usesRs1 = validOut and op not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- usesRs2 = validOut and op in {0110011 R, 0100011 S, 1100011 B}.
- hazardStall = exLw and exRd!=0 and ((usesRs1 and rs1==exRd) or (usesRs2 and rs2==exRd)).
- bubbleEx = hazardStall or redirect.
- Per-edge update priority (highest first):
  1. redirect=1: pcFetch<=redirectPc; instrOut<=NOP_INSTR; validOut<=0; pcOut/pcAdd4Out<=0. Overrides hazardStall and extStall.
  2. extStall=1: all registers hold.
  3. hazardStall=1: all registers hold. Stall self-clears next cycle because ID/EX holds a bubble (exLw=0).
  4. Normal: instrOut<=instrIn; pcOut<=pcFetch; pcAdd4Out<=pcFetch+4; validOut<=1; pcFetch<=pcFetch+4.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 wraps to 0 with no flag. Low two bits are not forced; redirectPc is taken verbatim.
- Fetch-to-decode latency is 1 cycle. Redirect penalty is 1 squashed slot in IF/ID plus the bubble in ID/EX.
- Single always block for state; no latches; outputs registered except bubbleEx and hazardStall.

Test Plan:
- Reset then sequential fetch: reset=0 for 2 cycles, release, instrIn=32'h00500093 constant -> pcFetch 0,4,8,12 on successive edges. After the first edge: pcOut=0, pcAdd4Out=4, validOut=1, instrOut=32'h00500093.
- Load-use on rs2: IF/ID holds add x3,x1,x2 (32'h002081B3), exLw=1, exRd=2 -> hazardStall=1 and bubbleEx=1 for one cycle, pcFetch and instrOut unchanged. Next cycle exLw=0 -> advance resumes.
- No false hazard: IF/ID holds lui x5 (32'h000122B7), exLw=1, exRd=0 and separately exRd=5 -> hazardStall=0 in both cases. exRd=0 with a matching rs1 on an addi -> hazardStall=0.
- Redirect with simultaneous stall: pcFetch=0x20, hazard active, extStall=1, redirect=1, redirectPc=0x100 -> next edge pcFetch=0x100, instrOut=0x00000013, validOut=0, bubbleEx=1 during that cycle.
- extStall hold: extStall=1 for 3 cycles at pcFetch=0x40 -> all outputs constant, bubbleEx=0. After release, pcFetch=0x44 after one edge.
- Wrap and reset mid-run: redirectPc=32'hFFFFFFFC, then one normal edge -> pcFetch=0, pcAdd4Out=0. Assert reset=0 while redirect=1 -> pcFetch=RESET_PC, validOut=0.
